// File: rtl/br_fifo_shared_pop_wrr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// br_fifo_shared_pop_wrr_arbiter_pkg
//
// Purpose: shared helpers for the pop-side weighted round-robin arbiter of the
//          shared dynamic multi-FIFO. The weight and credit widths are local
//          parameters of the modules, so this package defines no types. It
//          holds only sizing helpers.
// ---------------------------------------------------------------------------
package br_fifo_shared_pop_wrr_arbiter_pkg;

    // Width of the round-robin pointer. It is never narrower than one bit,
    // so a degenerate configuration still elaborates.
    function automatic int ptr_width(input int num_fifos);
        return (num_fifos <= 2) ? 1 : $clog2(num_fifos);
    endfunction

endpackage : br_fifo_shared_pop_wrr_arbiter_pkg

// File: rtl/br_fifo_shared_pop_wrr_arbiter_port.sv
// ---------------------------------------------------------------------------
// br_fifo_shared_pop_wrr_arbiter_port
//
// Purpose: a weighted round-robin arbiter for one read port. It keeps a
//          pointer and one credit counter per FIFO. The grant is a
//          combinational function of the requests and the current state.
//          State advances only on a commit (enable_priority_update with a
//          nonzero grant).
//
// Ports:
//   clk                     clock
//   rst                     asynchronous reset, active high
//   cfg_weight              per-FIFO weight; a weight of 0 acts as 1
//   request                 per-FIFO request
//   grant                   one-hot grant, or zero when there is no request
//   enable_priority_update  commits the current grant and advances state
//   round_start             high when this grant reloads all credits
// ---------------------------------------------------------------------------
module br_fifo_shared_pop_wrr_arbiter_port
    import br_fifo_shared_pop_wrr_arbiter_pkg::*;
#(
    parameter int NumFifos    = 2,
    parameter int WeightWidth = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumFifos-1:0][WeightWidth-1:0] cfg_weight,
    input  logic [NumFifos-1:0]                  request,
    output logic [NumFifos-1:0]                  grant,
    input  logic                                 enable_priority_update,
    output logic                                 round_start
);

    localparam int PtrWidth = ptr_width(NumFifos);

    typedef logic [PtrWidth-1:0]    ptr_t;
    typedef logic [WeightWidth-1:0] credit_t;

    localparam ptr_t    LastIdx   = ptr_t'(NumFifos - 1);
    localparam credit_t CreditOne = credit_t'(1);

    ptr_t                                 r_ptr;
    logic [NumFifos-1:0][WeightWidth-1:0] r_credit;

    logic [NumFifos-1:0][WeightWidth-1:0] w_eff_weight;
    logic [NumFifos-1:0]                  w_credit_nz;
    logic [NumFifos-1:0]                  w_eligible;
    logic                                 w_any_req;
    logic                                 w_any_elig;
    logic                                 w_replenish;
    logic                                 w_commit;
    ptr_t                                 w_elig_idx;
    ptr_t                                 w_req_idx;
    ptr_t                                 w_grant_idx;
    credit_t                              w_granted_credit;
    logic [NumFifos-1:0][WeightWidth-1:0] w_credit_nxt;
    ptr_t                                 w_ptr_nxt;

    // Finds the first set bit of vec in circular order, starting at index
    // start (inclusive). It rotates the vector right by start, takes the
    // lowest set bit, and maps that offset back to an absolute index.
    function automatic ptr_t first_from(input logic [NumFifos-1:0] vec,
                                        input ptr_t                start);
        logic [2*NumFifos-1:0] dbl;
        logic [NumFifos-1:0]   rot;
        ptr_t                  off;
        logic [PtrWidth:0]     sum;
        dbl = {vec, vec} >> start;
        rot = dbl[NumFifos-1:0];
        off = '0;
        for (int k = NumFifos - 1; k >= 0; k--) begin
            if (rot[k]) off = ptr_t'(k);
        end
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= (PtrWidth+1)'(NumFifos)) sum = sum - (PtrWidth+1)'(NumFifos);
        return sum[PtrWidth-1:0];
    endfunction

    always_comb begin
        w_eff_weight = cfg_weight;
        w_credit_nz  = '0;
        for (int i = 0; i < NumFifos; i++) begin
            if (cfg_weight[i] == '0) w_eff_weight[i] = CreditOne;
            w_credit_nz[i] = |r_credit[i];
        end
    end

    assign w_eligible  = request & w_credit_nz;
    assign w_any_req   = |request;
    assign w_any_elig  = |w_eligible;
    // A replenish happens when FIFOs are requesting but every one of them
    // has used up its credit.
    assign w_replenish = w_any_req & ~w_any_elig;
    assign w_commit    = enable_priority_update & w_any_req;

    assign w_elig_idx  = first_from(w_eligible, r_ptr);
    assign w_req_idx   = first_from(request, r_ptr);
    assign w_grant_idx = w_any_elig ? w_elig_idx : w_req_idx;

    assign grant       = w_any_req ? (NumFifos'(1) << w_grant_idx) : '0;
    assign round_start = w_replenish;

    // On a normal grant the granted credit is nonzero, so decrementing it
    // cannot underflow. On a replenish the granted FIFO spends one credit
    // from the freshly loaded weight.
    assign w_granted_credit = w_replenish ? (w_eff_weight[w_grant_idx] - CreditOne)
                                          : (r_credit[w_grant_idx] - CreditOne);

    always_comb begin
        w_credit_nxt = r_credit;
        w_ptr_nxt    = r_ptr;
        if (w_commit) begin
            // A reload overwrites every credit, so credits left unused by
            // idle FIFOs are thrown away instead of building up.
            if (w_replenish) w_credit_nxt = w_eff_weight;
            w_credit_nxt[w_grant_idx] = w_granted_credit;
            // The pointer stays on the granted FIFO while it still has credit,
            // which gives it a burst. Once the credit is spent, the pointer
            // moves to the next FIFO.
            if (w_granted_credit == '0) begin
                w_ptr_nxt = (w_grant_idx == LastIdx) ? '0 : (w_grant_idx + ptr_t'(1));
            end else begin
                w_ptr_nxt = w_grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= '0;
            r_credit <= '0;
        end else begin
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(grant));
    a_grant_subset : assert property (@(posedge clk) disable iff (rst)
        (grant & ~request) == '0);
    a_work_conserving : assert property (@(posedge clk) disable iff (rst)
        (|request) |-> (|grant));
    a_round_start_grant : assert property (@(posedge clk) disable iff (rst)
        round_start |-> (|grant));
    a_inputs_known : assert property (@(posedge clk) disable iff (rst)
        !$isunknown({request, enable_priority_update}));

endmodule : br_fifo_shared_pop_wrr_arbiter_port

// File: rtl/br_fifo_shared_pop_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// br_fifo_shared_pop_wrr_arbiter
//
// Purpose: the pop-side weighted round-robin arbiter for the shared dynamic
//          multi-FIFO. It contains one independent arbiter per read port, and
//          all ports share the same weight configuration. The arbiter always
//          grants when any request is present, so the controller can assume
//          ArbiterAlwaysGrants.
//
// Ports:
//   clk                     clock
//   rst                     asynchronous reset, active high
//   cfg_weight              per-FIFO weight, sent to every port
//   request                 per-port, per-FIFO request
//   grant                   per-port grant, one-hot or zero
//   enable_priority_update  per-port commit of the current grant
//   round_start             per-port flag marking a credit reload
// ---------------------------------------------------------------------------
module br_fifo_shared_pop_wrr_arbiter
    import br_fifo_shared_pop_wrr_arbiter_pkg::*;
#(
    parameter int NumReadPorts = 1,
    parameter int NumFifos     = 2,
    parameter int WeightWidth  = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NumFifos-1:0][WeightWidth-1:0] cfg_weight,
    input  logic [NumReadPorts-1:0][NumFifos-1:0] request,
    output logic [NumReadPorts-1:0][NumFifos-1:0] grant,
    input  logic [NumReadPorts-1:0]               enable_priority_update,
    output logic [NumReadPorts-1:0]               round_start
);

    for (genvar p = 0; p < NumReadPorts; p++) begin : g_port
        br_fifo_shared_pop_wrr_arbiter_port #(
            .NumFifos    (NumFifos),
            .WeightWidth (WeightWidth)
        ) u_port (
            .clk                    (clk),
            .rst                    (rst),
            .cfg_weight             (cfg_weight),
            .request                (request[p]),
            .grant                  (grant[p]),
            .enable_priority_update (enable_priority_update[p]),
            .round_start            (round_start[p])
        );
    end

endmodule : br_fifo_shared_pop_wrr_arbiter

// File: tb/tb_br_fifo_shared_pop_wrr_arbiter.sv
module tb_br_fifo_shared_pop_wrr_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // three FIFOs, one port
    logic [2:0][3:0] wt3;
    logic [0:0][2:0] req3;
    logic [0:0][2:0] gnt3;
    logic [0:0]      en3;
    logic [0:0]      rs3;

    // two FIFOs, two ports
    logic [1:0][3:0] wt2;
    logic [1:0][1:0] req2;
    logic [1:0][1:0] gnt2;
    logic [1:0]      en2;
    logic [1:0]      rs2;

    br_fifo_shared_pop_wrr_arbiter #(
        .NumReadPorts (1),
        .NumFifos     (3),
        .WeightWidth  (4)
    ) dut3 (
        .clk                    (clk),
        .rst                    (rst),
        .cfg_weight             (wt3),
        .request                (req3),
        .grant                  (gnt3),
        .enable_priority_update (en3),
        .round_start            (rs3)
    );

    br_fifo_shared_pop_wrr_arbiter #(
        .NumReadPorts (2),
        .NumFifos     (2),
        .WeightWidth  (4)
    ) dut2 (
        .clk                    (clk),
        .rst                    (rst),
        .cfg_weight             (wt2),
        .request                (req2),
        .grant                  (gnt2),
        .enable_priority_update (en2),
        .round_start            (rs2)
    );

    typedef struct {
        bit          rst_before;
        logic [2:0]  req;
        logic        en;
        logic [11:0] wt;
        logic [2:0]  g;
        logic        rs;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // weights packed with FIFO 2 in the most significant nibble
    localparam logic [11:0] W213 = {4'd3, 4'd1, 4'd2};
    localparam logic [11:0] W000 = 12'd0;
    localparam logic [11:0] W400 = {4'd0, 4'd0, 4'd4};

    task automatic add(input bit r, input logic [2:0] rq, input logic e,
                       input logic [11:0] w, input logic [2:0] g, input logic s);
        vec_t v;
        v.rst_before = r; v.req = rq; v.en = e; v.wt = w; v.g = g; v.rs = s;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx,
                         input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        wt3  = W213; req3 = '0; en3 = '0;
        wt2  = {4'd1, 4'd1}; req2 = '0; en2 = '0;
        @(negedge clk);
        rst = 1'b0;

        // weights {2,1,3}, all requesting
        add(1, 3'b111, 1, W213, 3'b001, 1);
        add(0, 3'b111, 1, W213, 3'b001, 0);
        add(0, 3'b111, 1, W213, 3'b010, 0);
        add(0, 3'b111, 1, W213, 3'b100, 0);
        add(0, 3'b111, 1, W213, 3'b100, 0);
        add(0, 3'b111, 1, W213, 3'b100, 0);
        add(0, 3'b111, 1, W213, 3'b001, 1);
        add(0, 3'b111, 1, W213, 3'b001, 0);
        add(0, 3'b111, 1, W213, 3'b010, 0);
        // enable held low for three cycles
        add(1, 3'b111, 1, W213, 3'b001, 1);
        add(0, 3'b111, 0, W213, 3'b001, 0);
        add(0, 3'b111, 0, W213, 3'b001, 0);
        add(0, 3'b111, 0, W213, 3'b001, 0);
        add(0, 3'b111, 1, W213, 3'b001, 0);
        add(0, 3'b111, 1, W213, 3'b010, 0);
        add(0, 3'b111, 1, W213, 3'b100, 0);
        add(0, 3'b111, 1, W213, 3'b100, 0);
        add(0, 3'b111, 1, W213, 3'b100, 0);
        add(0, 3'b111, 1, W213, 3'b001, 1);
        // idle, then requests from FIFO 2 only (idle cycle mid-burst)
        add(1, 3'b000, 1, W213, 3'b000, 0);
        add(0, 3'b000, 1, W213, 3'b000, 0);
        add(1, 3'b100, 1, W213, 3'b100, 1);
        add(0, 3'b100, 1, W213, 3'b100, 0);
        add(0, 3'b000, 1, W213, 3'b000, 0);
        add(0, 3'b100, 1, W213, 3'b100, 0);
        add(0, 3'b100, 1, W213, 3'b100, 1);
        // weights of zero, then weight[0]=4 changed mid-round
        add(1, 3'b111, 1, W000, 3'b001, 1);
        add(0, 3'b111, 1, W000, 3'b010, 0);
        add(0, 3'b111, 1, W000, 3'b100, 0);
        add(0, 3'b111, 1, W000, 3'b001, 1);
        add(0, 3'b111, 1, W400, 3'b010, 0);
        add(0, 3'b111, 1, W400, 3'b100, 0);
        add(0, 3'b111, 1, W400, 3'b001, 1);
        add(0, 3'b111, 1, W400, 3'b001, 0);
        add(0, 3'b111, 1, W400, 3'b001, 0);
        add(0, 3'b111, 1, W400, 3'b001, 0);
        add(0, 3'b111, 1, W400, 3'b010, 0);
        add(0, 3'b111, 1, W400, 3'b100, 0);
        add(0, 3'b111, 1, W400, 3'b001, 1);

        foreach (vecs[i]) begin
            if (vecs[i].rst_before) pulse_rst();
            req3[0] = vecs[i].req;
            en3[0]  = vecs[i].en;
            wt3     = vecs[i].wt;
            #1;
            check("vec_grant", i, 8'(gnt3[0]), 8'(vecs[i].g));
            check("vec_round_start", i, 8'(rs3[0]), 8'(vecs[i].rs));
            @(negedge clk);
        end
        req3 = '0; en3 = '0;

        // two ports are independent: port0 requests 11, port1 requests 10
        pulse_rst();
        wt2  = {4'd1, 4'd1};
        req2 = {2'b10, 2'b11};
        en2  = 2'b11;
        for (int c = 0; c < 4; c++) begin
            logic [1:0] exp_g0;
            logic [1:0] exp_rs;
            exp_g0 = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_rs = (c % 2 == 0) ? 2'b11 : 2'b10;
            #1;
            check("mp_grant0", c, 8'(gnt2[0]), 8'(exp_g0));
            check("mp_grant1", c, 8'(gnt2[1]), 8'(2'b10));
            check("mp_round_start", c, 8'(rs2), 8'(exp_rs));
            @(negedge clk);
        end
        req2 = '0; en2 = '0;

        // asynchronous reset in the middle of a FIFO 2 burst
        pulse_rst();
        wt3 = W213; req3[0] = 3'b100; en3[0] = 1'b1;
        #1;
        check("ar_first_grant", 0, 8'(gnt3[0]), 8'(3'b100));
        @(negedge clk);
        req3[0] = 3'b111; en3[0] = 1'b0;
        #1;
        check("ar_burst_grant", 0, 8'(gnt3[0]), 8'(3'b100));
        check("ar_burst_rs", 0, 8'(rs3[0]), 8'(1'b0));
        rst = 1'b1;
        #1;
        check("ar_in_reset_grant", 0, 8'(gnt3[0]), 8'(3'b001));
        check("ar_in_reset_rs", 0, 8'(rs3[0]), 8'(1'b1));
        @(negedge clk);
        rst = 1'b0; en3[0] = 1'b1;
        #1;
        check("ar_post_grant", 0, 8'(gnt3[0]), 8'(3'b001));
        check("ar_post_rs", 0, 8'(rs3[0]), 8'(1'b1));
        @(negedge clk);
        #1;
        check("ar_next_grant", 0, 8'(gnt3[0]), 8'(3'b001));
        check("ar_next_rs", 0, 8'(rs3[0]), 8'(1'b0));
        @(negedge clk);
        req3 = '0; en3 = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_br_fifo_shared_pop_wrr_arbiter

// File: doc/br_fifo_shared_pop_wrr_arbiter.md
Name: br_fifo_shared_pop_wrr_arbiter

Overview:
- Weighted round-robin (WRR) arbiter for the pop side of the shared dynamic multi-FIFO.
- Plugs into the external arbiter interface of the shared dynamic FIFO controller: the request, grant and enable_priority_update bundles, one arbiter per read port.
- Each logical FIFO receives read-port bandwidth in proportion to a configurable weight.
- Work-conserving: grants whenever any request is asserted, so the controller can be built with ArbiterAlwaysGrants=1.

Parameters:
- NumReadPorts, 1: number of independent arbiters. Must be >=1.
- NumFifos, 2: requesters per arbiter. Must be >=2.
- WeightWidth, 4: width of the weight and credit counters. Must be >=1.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- cfg_weight  input  NumFifos x WeightWidth  per-FIFO weight, shared by all ports. Value 0 is treated as 1.
- request  input  NumReadPorts x NumFifos  per-port requests.
- grant  output  NumReadPorts x NumFifos  per-port grant; one-hot or zero.
- enable_priority_update  input  NumReadPorts  when 1, the grant is committed and state advances.
- round_start  output  NumReadPorts  1 when this cycle's grant begins a new credit round (for perf counters).

Behaviour:
- Ports are fully independent; nothing below couples one port to another.
- State per port:
  - ptr, clog2(NumFifos) bits: next requester to consider.
  - credit[i], WeightWidth bits, for each FIFO i.
- Reset (asynchronous, active-high): ptr=0, all credits=0. State holds reset values until rst deasserts. No mid-operation recovery is needed beyond this.
- Grant is combinational from request and current state, with zero latency.
  - grant is 0 iff request is 0.
  - round_start is 0 whenever grant is 0.
- Eligible set: eligible = request AND (credit != 0).
- Normal path (eligible nonzero):
  - Grant the first eligible index in circular order starting at ptr (inclusive).
  - round_start=0.
- Replenish path (eligible zero, request nonzero):
  - Grant the first requesting index in circular order starting at ptr (inclusive).
  - round_start=1.
- Commit (enable_priority_update=1 and grant nonzero; g = granted index):
  - Normal path: credit[g] decrements by 1.
  - Replenish path: every credit[i] loads eff_weight[i], where eff_weight = max(cfg_weight, 1). Then credit[g] = eff_weight[g]-1.
  - ptr update: if the resulting credit[g] is 0, ptr = (g+1) mod NumFifos (wrap from NumFifos-1 to 0). Otherwise ptr = g, so the same FIFO keeps the grant for a burst.
- No commit (enable_priority_update=0, or grant zero): state holds. The same request pattern yields the same grant next cycle.
- Credit arithmetic:
  - Credits never underflow; decrement happens only when credit != 0.
  - Unused credits of non-requesting FIFOs are discarded at the next replenish; there is no accumulation.
- cfg_weight changes take effect only at the next replenish. Current credits are untouched.
- Request may drop mid-burst. The next eligible FIFO in circular order from ptr is granted, and ptr moves only on commit.
- Assertions:
  - grant is onehot0.
  - grant is a subset of request.
  - request nonzero implies grant nonzero.
  - round_start implies grant nonzero.
  - request and enable_priority_update are known outside reset.

Decomposition:
- No new package types; weight and credit widths are local parameters.
- Natural sub-module: br_fifo_shared_pop_wrr_arbiter_port. It holds ptr, credits, the two circular first-one searches (a rotate by ptr, priority encode, rotate back) and the commit logic.
- The top level instantiates one sub-module per read port in a generate loop and broadcasts cfg_weight to all of them.

Test Plan:
- Weights: N=3, weights {2,1,3}, request=3'b111 every cycle, enable=1, one port.
  - Grant index sequence is 0,0,1,2,2,2,0,0,1,…
  - round_start=1 at cycles 0 and 6 only.
- Enable hold: the same config with enable=0 for 3 cycles after cycle 1.
  - grant stays at index 0 for those cycles.
  - The sequence resumes 0,1,2,2,2 once enable=1.
- Idle and sparse request: request=0 gives grant=0, round_start=0 and no state change even with enable=1. Then request=3'b100 after a reset:
  - replenish, grant index 2, with credit[2]=2 left;
  - index 2 granted 3 consecutive cycles;
  - the 4th cycle replenishes again (round_start=1).
- Weight 0 and a mid-round weight change:
  - weights {0,0,0} behave as pure round-robin: 0,1,2,0,…
  - changing weight[0] to 4 mid-round gives 4 consecutive grants to index 0 only after the next round_start.
- Multi-port independence: NumReadPorts=2, port0 request=2'b11, port1 request=2'b10, weights {1,1}. Port0 alternates 0,1,0,1 while port1 always grants 1.
- Asynchronous reset mid-burst: assert rst between clock edges while index 2 holds credit.
  - State clears immediately.
  - After deassertion, request=3'b111 grants index 0 with round_start=1.
